// File: rtl/calc_sequencer.sv
// Entry-driven calculator: A, operator and B are strobed in one at a time,
// then an add/sub (single cycle) or iterative mul/div runs before one DONE cycle.
module calc_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               input_Clear,
   input  logic               input_Valid,
   input  logic [WIDTH-1:0]   input_Data,
   input  logic [1:0]         input_Operator,
   output logic               busy,
   output logic               result_Valid,
   output logic [2*WIDTH-1:0] result,
   output logic               error,
   output logic [2:0]         state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [1:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 rv_q, rv_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 error_q, error_d;

   logic [2*WIDTH-1:0]   mul_acc;
   logic [WIDTH:0]       r_sh;
   logic                 r_ge;
   logic [WIDTH-1:0]     r_new;
   logic [2*WIDTH-1:0]   div_acc;
   logic                 last;
   logic                 finish;
   logic [2*WIDTH-1:0]   fin_res;

   // acc holds the running product for mul, and {remainder, quotient} for div
   always_comb begin
      mul_acc = acc_q + (b_q[0] ? mcand_q : '0);
      r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      r_ge    = r_sh >= {1'b0, b_q};
      r_new   = r_ge ? (r_sh[WIDTH-1:0] - b_q) : r_sh[WIDTH-1:0];
      div_acc = {r_new, acc_q[WIDTH-2:0], r_ge};
      last    = cnt_q == CW'(WIDTH - 1);
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      rv_d     = 1'b0;
      result_d = result_q;
      error_d  = error_q;
      finish   = 1'b0;
      fin_res  = '0;

      case (state_q)
         S_A: begin
            if (input_Valid) begin
               a_d     = input_Data;
               state_d = S_OP;
            end
         end
         S_OP: begin
            if (input_Valid) begin
               op_d    = input_Operator;
               state_d = S_B;
            end
         end
         S_B: begin
            if (input_Valid) begin
               b_d     = input_Data;
               state_d = S_EXEC;
               busy_d  = 1'b1;
               cnt_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, a_q};
               acc_d   = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, a_q} : '0;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + CW'(1);
            unique case (op_q)
               OP_ADD: begin
                  finish  = 1'b1;
                  fin_res = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
               end
               OP_SUB: begin
                  finish  = 1'b1;
                  fin_res = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
               end
               OP_MUL: begin
                  acc_d   = mul_acc;
                  mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                  b_d     = {1'b0, b_q[WIDTH-1:1]};
                  finish  = last;
                  fin_res = mul_acc;
               end
               OP_DIV: begin
                  if (b_q == '0) begin
                     finish  = 1'b1;
                     fin_res = '0;
                     error_d = 1'b1;
                  end else begin
                     acc_d   = div_acc;
                     finish  = last;
                     fin_res = div_acc;
                  end
               end
            endcase
            if (finish) begin
               state_d  = S_DONE;
               rv_d     = 1'b1;
               result_d = fin_res;
            end
         end
         S_DONE: begin
            state_d = S_A;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_A;
            busy_d  = 1'b0;
         end
      endcase

      if (input_Clear) begin
         state_d  = S_A;
         a_d      = '0;
         b_d      = '0;
         op_d     = '0;
         acc_d    = '0;
         mcand_d  = '0;
         cnt_d    = '0;
         busy_d   = 1'b0;
         rv_d     = 1'b0;
         result_d = '0;
         error_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   // a clear arriving during DONE still kills the pulse in that cycle
   assign result_Valid = rv_q & ~input_Clear;
   assign busy         = busy_q;
   assign result       = result_q;
   assign error        = error_q;
   assign state        = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed checks of calc_sequencer against an arithmetic
// reference model (values, latency, sticky error, clear/reset behaviour).
module tb_calc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic [1:0]  in_op = '0;
   logic        busy, rv, error;
   logic [15:0] result;
   logic [2:0]  state;

   calc_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .input_Clear(in_clear), .input_Valid(in_valid),
      .input_Data(in_data), .input_Operator(in_op), .busy(busy),
      .result_Valid(rv), .result(result), .error(error), .state(state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int tb_t = 0;
   logic err_m = 1'b0;

   function automatic logic [15:0] model_res(input int a, input int op, input int b);
      int r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a * b;
         default: r = (b == 0) ? 0 : ((a % b) * 256 + a / b);
      endcase
      return 16'(r);
   endfunction

   function automatic int model_lat(input int op, input int b);
      if (op < 2 || (op == 3 && b == 0)) return 2;
      return 1 + 8;
   endfunction

   task automatic enter(input int a, input int op, input int b);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(a); in_op = 2'($urandom);
      @(negedge clk);
      in_op = 2'(op); in_data = 8'($urandom);
      @(negedge clk);
      in_data = 8'(b); in_op = 2'($urandom);
      tb_t = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat, output bit ok);
      ok = 1'b0;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (rv === 1'b1) begin
            ok = 1'b1;
            lat = cyc - tb_t;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if (state !== 3'd0 || busy !== 1'b0 || rv !== 1'b0 ||
          result !== 16'h0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: state=%0d busy=%b rv=%b result=%h error=%b, want all zero",
                  state, busy, rv, result, error);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat; bit ok;
      enter(25, 0, 17);
      n_chk++;
      if (busy !== 1'b1 || rv !== 1'b0) begin
         n_fail++;
         $display("FAIL add_t1: busy=%b rv=%b, want busy=1 rv=0", busy, rv);
      end
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 2 || result !== 16'h002A || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL add: ok=%0d lat=%0d result=%h busy=%b, want lat=2 result=002a busy=1",
                  ok, lat, result, busy);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || state !== 3'd0 || rv !== 1'b0) begin
         n_fail++;
         $display("FAIL add_after: busy=%b state=%0d rv=%b, want 0 0 0", busy, state, rv);
      end
   endtask

   task automatic test_sub();
      int lat; bit ok;
      enter(5, 1, 9);
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 2 || result !== 16'hFFFC || error !== 1'b0) begin
         n_fail++;
         $display("FAIL sub: ok=%0d lat=%0d result=%h error=%b, want lat=2 result=fffc error=0",
                  ok, lat, result, error);
      end
   endtask

   task automatic test_mul();
      int lat; bit ok;
      enter(200, 2, 3);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (rv !== 1'b0 || busy !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL mul_exec: rv=%b busy=%b state=%0d, want 0 1 3", rv, busy, state);
         end
         in_valid = 1'b1; in_data = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 9 || result !== 16'h0258) begin
         n_fail++;
         $display("FAIL mul: ok=%0d lat=%0d result=%h, want lat=9 result=0258", ok, lat, result);
      end
      @(negedge clk);
      n_chk++;
      if (rv !== 1'b0 || state !== 3'd0 || result !== 16'h0258) begin
         n_fail++;
         $display("FAIL mul_pulse: rv=%b state=%0d result=%h, want 0 0 0258", rv, state, result);
      end
   endtask

   task automatic test_div();
      int lat; bit ok;
      enter(100, 3, 7);
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 9 || result !== 16'h020E || error !== 1'b0) begin
         n_fail++;
         $display("FAIL div: ok=%0d lat=%0d result=%h error=%b, want lat=9 result=020e error=0",
                  ok, lat, result, error);
      end
      enter(50, 3, 0);
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 2 || result !== 16'h0000 || error !== 1'b1) begin
         n_fail++;
         $display("FAIL div0: ok=%0d lat=%0d result=%h error=%b, want lat=2 result=0000 error=1",
                  ok, lat, result, error);
      end
      enter(1, 0, 1);
      wait_result(lat, ok);
      n_chk++;
      if (!ok || result !== 16'h0002 || error !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: ok=%0d result=%h error=%b, want result=0002 error=1",
                  ok, result, error);
      end
      @(negedge clk);
      in_clear = 1'b1;
      @(negedge clk);
      in_clear = 1'b0;
      n_chk++;
      if (error !== 1'b0 || result !== 16'h0 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL err_clear: error=%b result=%h state=%0d, want 0 0 0", error, result, state);
      end
      err_m = 1'b0;
   endtask

   task automatic test_clear_mid_mul();
      int lat; bit ok; bit seen;
      enter(3, 0, 4);
      wait_result(lat, ok);
      enter(7, 2, 9);
      while (cyc < tb_t + 4) @(negedge clk);
      in_clear = 1'b1;
      @(negedge clk);
      in_clear = 1'b0;
      n_chk++;
      if (state !== 3'd0 || busy !== 1'b0 || result !== 16'h0 || rv !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_mul: state=%0d busy=%b result=%h rv=%b, want 0 0 0000 0",
                  state, busy, result, rv);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rv === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      n_chk++;
      if (seen) begin
         n_fail++;
         $display("FAIL clr_mul_pulse: result_Valid seen=1, want 0");
      end
      enter(9, 0, 6);
      wait_result(lat, ok);
      n_chk++;
      if (!ok || lat != 2 || result !== 16'd15) begin
         n_fail++;
         $display("FAIL clr_reentry: ok=%0d lat=%0d result=%h, want lat=2 result=000f",
                  ok, lat, result);
      end
   endtask

   task automatic test_rst_mid_div();
      int lat; bit ok; bit seen;
      enter(5, 3, 0);
      wait_result(lat, ok);
      enter(200, 3, 9);
      while (cyc < tb_t + 3) @(negedge clk);
      rst = 1'b1; in_clear = 1'b1; in_valid = 1'b1; in_data = 8'd55;
      @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if (state !== 3'd0 || busy !== 1'b0 || rv !== 1'b0 ||
          result !== 16'h0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_div: state=%0d busy=%b rv=%b result=%h error=%b, want all zero",
                  state, busy, rv, result, error);
      end
      err_m = 1'b0;
      @(negedge clk);
      in_clear = 1'b0; in_valid = 1'b0;
      n_chk++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL clr_valid: state=%0d, want 0", state);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rv === 1'b1 || state !== 3'd0) seen = 1'b1;
         @(negedge clk);
      end
      n_chk++;
      if (seen) begin
         n_fail++;
         $display("FAIL rst_quiet: activity seen after reset, want none");
      end
   endtask

   task automatic test_random();
      int lat; bit ok;
      int a, op, b;
      for (int k = 0; k < 30; k++) begin
         a  = int'($urandom_range(0, 255));
         op = int'($urandom_range(0, 3));
         b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
         if (op == 3 && b == 0) err_m = 1'b1;
         enter(a, op, b);
         wait_result(lat, ok);
         n_chk++;
         if (!ok || lat != model_lat(op, b) || result !== model_res(a, op, b) ||
             error !== err_m) begin
            n_fail++;
            $display("FAIL rand a=%0d op=%0d b=%0d: ok=%0d lat=%0d result=%h error=%b, want lat=%0d result=%h error=%b",
                     a, op, b, ok, lat, result, error, model_lat(op, b),
                     model_res(a, op, b), err_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_clear_mid_mul();
      test_rst_mid_div();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 input_Clear  input  1  synchronous abort/clear of the current calculation.
REQ-006 input_Valid  input  1  one-cycle entry strobe for the current entry phase.
REQ-007 input_Data  input  WIDTH  unsigned operand value, sampled with input_Valid.
REQ-008 input_Operator  input  2  operator code, sampled with input_Valid: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 busy  output  1  high in EXEC and DONE; input_Valid is ignored while high.
REQ-010 result_Valid  output  1  one-cycle pulse when result is updated.
REQ-011 result  output  2*WIDTH  last completed result, held until overwritten or cleared.
REQ-012 error  output  1  sticky divide-by-zero flag.
REQ-013 state  output  3  current FSM state code, for debug.

Function
REQ-014 The FSM SHALL have five states with fixed encodings: S_A=0, S_OP=1, S_B=2, S_EXEC=3, S_DONE=4.
REQ-015 In S_A, input_Valid SHALL capture input_Data as A and move the FSM to S_OP.
REQ-016 In S_OP, input_Valid SHALL capture input_Operator as OP and move the FSM to S_B; input_Data is ignored in this state.
REQ-017 In S_B, input_Valid SHALL capture input_Data as B and move the FSM to S_EXEC on the next cycle, t+1.
REQ-018 In S_A, S_OP and S_B, the FSM SHALL hold its state while input_Valid=0.
REQ-019 Add SHALL take 1 EXEC cycle, with result = zero-extended A+B (carry lands in bit WIDTH).
REQ-020 Sub SHALL take 1 EXEC cycle, with result = A-B as a 2*WIDTH two's-complement value (sign-extended).
REQ-021 Mul SHALL be an iterative shift-add taking exactly WIDTH EXEC cycles, with result = A*B unsigned.
REQ-022 Div SHALL be an iterative restoring divide taking exactly WIDTH EXEC cycles, with result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-023 Div with B=0 SHALL take 1 EXEC cycle, then set result=0 and error=1.
REQ-024 After EXEC completes, the FSM SHALL enter S_DONE for exactly 1 cycle, assert result_Valid=1 and update result in that same cycle, then return to S_A.
REQ-025 Latency from the B strobe at cycle t to the result_Valid pulse SHALL be t+2 for add, sub and div-by-zero, and t+1+WIDTH for mul and div.
REQ-026 error SHALL stay set across later calculations until input_Clear or rst.
REQ-027 A successful operation SHALL NOT clear error.
REQ-028 input_Clear SHALL, in any state, move the FSM to S_A next cycle.
REQ-029 input_Clear SHALL zero A, B, OP, result, error and the iteration counter.
REQ-030 input_Clear SHALL suppress result_Valid, including during EXEC or DONE.
REQ-031 Priority SHALL be rst > input_Clear > input_Valid; input_Valid in the same cycle as input_Clear is discarded.
REQ-032 input_Valid during S_EXEC or S_DONE SHALL be ignored, with no queuing.
REQ-033 The iteration counter SHALL be sized to hold WIDTH and SHALL NOT wrap during EXEC.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL set state=S_A, busy=0, result_Valid=0, result=0 and error=0, and clear all internal registers.
REQ-035 rst during EXEC SHALL abort the operation with no result_Valid pulse.
REQ-036 The first legal entry SHALL be the cycle after rst deasserts.

Verification (WIDTH=8)
REQ-037 The bench SHALL check: A=25, OP=00, B=17 -> result=0x002A with result_Valid at t+2 and busy high for t+1..t+2.
REQ-038 The bench SHALL check: A=5, OP=01, B=9 -> result=0xFFFC at t+2 and error=0.
REQ-039 The bench SHALL check: A=200, OP=10, B=3 -> result=0x0258 at t+9, result_Valid high for exactly 1 cycle, and input_Valid pulses during EXEC having no effect.
REQ-040 The bench SHALL check: A=100, OP=11, B=7 -> result=0x020E at t+9; then A=50, OP=11, B=0 -> result=0x0000 and error=1 at t+2; error stays 1 through a following 1+1 add; input_Clear drops error to 0.
REQ-041 The bench SHALL check: input_Clear at cycle t+4 of a multiply -> no result_Valid, state=0 and busy=0 at t+5, result=0, and a new entry is accepted normally.
REQ-042 The bench SHALL check: rst mid-divide, plus input_Clear and input_Valid in the same cycle -> all outputs reset and the simultaneous entry is discarded (state stays S_A).
